// File: rtl/rgb_led_arbiter.sv
// rgb_led_arbiter: fixed-priority owner of the board RGB LED, with minimum hold, per-tick fade and 8-bit PWM
// Ports:
//   CLK_10MHz, RST (async, active-high)
//   req[2:0]          request lines, req[0] highest priority
//   color0..2[23:0]   requester colours {R,G,B}
//   grant[2:0]        one-hot owner, 0 when idle
//   cur_r/g/b[7:0]    displayed channel amounts
//   settled           displayed colour equals target
//   rgb_r/g/b_pwm     PWM drive for the SB_RGBA_DRV inputs
module rgb_led_arbiter #(
  parameter int PWM_DIV  = 99,
  parameter int FADE_DIV = 19999,
  parameter int MIN_HOLD = 250
) (
  input  logic        CLK_10MHz,
  input  logic        RST,
  input  logic [2:0]  req,
  input  logic [23:0] color0,
  input  logic [23:0] color1,
  input  logic [23:0] color2,
  output logic [2:0]  grant,
  output logic [7:0]  cur_r,
  output logic [7:0]  cur_g,
  output logic [7:0]  cur_b,
  output logic        settled,
  output logic        rgb_r_pwm,
  output logic        rgb_g_pwm,
  output logic        rgb_b_pwm
);
  localparam int PW = PWM_DIV > 0 ? $clog2(PWM_DIV + 1) : 1;
  localparam int FW = FADE_DIV > 0 ? $clog2(FADE_DIV + 1) : 1;
  localparam int HW = MIN_HOLD > 0 ? $clog2(MIN_HOLD + 1) : 1;
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_nxt;
  logic [PW-1:0] pwm_div_cnt;
  logic [FW-1:0] fade_div_cnt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic [7:0] pwm_cnt;
  logic [2:0] grant_nxt, hi, lo;
  logic [23:0] target;
  logic pwm_tick, fade_tick;
  function automatic logic [2:0] pick(input logic [2:0] r);
    return r[0] ? 3'b001 : r[1] ? 3'b010 : r[2] ? 3'b100 : 3'b000;
  endfunction
  function automatic logic [7:0] step(input logic [7:0] c, input logic [7:0] t);
    return c < t ? c + 8'd1 : c > t ? c - 8'd1 : c;
  endfunction
  assign pwm_tick  = pwm_div_cnt == PW'(PWM_DIV);
  assign fade_tick = fade_div_cnt == FW'(FADE_DIV);
  assign target  = grant[0] ? color0 : grant[1] ? color1 : grant[2] ? color2 : 24'h0;
  assign settled = {cur_r, cur_g, cur_b} == target;
  // requests that may preempt the owner, and those that may inherit once its hold expires
  assign hi = grant[2] ? req & 3'b011 : grant[1] ? req & 3'b001 : 3'b000;
  assign lo = grant[0] ? req & 3'b110 : grant[1] ? req & 3'b100 : 3'b000;
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    hold_nxt  = hold_cnt;
    if (state == IDLE) begin
      if (|req) begin
        state_nxt = ACTIVE;
        grant_nxt = pick(req);
        hold_nxt  = HW'(MIN_HOLD);
      end
    end else if (|hi) begin
      grant_nxt = pick(hi);
      hold_nxt  = HW'(MIN_HOLD);
    end else if (|(req & grant)) begin
      hold_nxt = HW'(MIN_HOLD);
    end else if (hold_cnt == '0) begin
      if (|lo) begin
        grant_nxt = pick(lo);
        hold_nxt  = HW'(MIN_HOLD);
      end else begin
        state_nxt = IDLE;
        grant_nxt = 3'b000;
      end
    end else if (fade_tick) begin
      hold_nxt = hold_cnt - 1'b1;
    end
  end
  always_ff @(posedge CLK_10MHz or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      grant    <= 3'b000;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      hold_cnt <= hold_nxt;
    end
  end
  always_ff @(posedge CLK_10MHz or posedge RST) begin
    if (RST) begin
      pwm_div_cnt  <= '0;
      fade_div_cnt <= '0;
      pwm_cnt      <= '0;
      cur_r        <= '0;
      cur_g        <= '0;
      cur_b        <= '0;
      rgb_r_pwm    <= 1'b0;
      rgb_g_pwm    <= 1'b0;
      rgb_b_pwm    <= 1'b0;
    end else begin
      pwm_div_cnt  <= pwm_tick ? '0 : pwm_div_cnt + 1'b1;
      fade_div_cnt <= fade_tick ? '0 : fade_div_cnt + 1'b1;
      if (pwm_tick) begin
        pwm_cnt   <= pwm_cnt + 8'd1;
        rgb_r_pwm <= pwm_cnt < cur_r;
        rgb_g_pwm <= pwm_cnt < cur_g;
        rgb_b_pwm <= pwm_cnt < cur_b;
      end
      if (fade_tick) begin
        cur_r <= step(cur_r, target[23:16]);
        cur_g <= step(cur_g, target[15:8]);
        cur_b <= step(cur_b, target[7:0]);
      end
    end
  end
endmodule

// File: tb/tb_rgb_led_arbiter.sv
// tb_rgb_led_arbiter: directed bench for rgb_led_arbiter with PWM_DIV=0, FADE_DIV=3, MIN_HOLD=2
module tb_rgb_led_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic [2:0] req, grant;
  logic [23:0] color0, color1, color2;
  logic [7:0] cur_r, cur_g, cur_b;
  logic settled, rgb_r_pwm, rgb_g_pwm, rgb_b_pwm;
  int tests = 0;
  int fails = 0;
  int nr, ng, nb;
  rgb_led_arbiter #(.PWM_DIV(0), .FADE_DIV(3), .MIN_HOLD(2)) dut (
    .CLK_10MHz(clk),
    .RST(rst),
    .req(req),
    .color0(color0),
    .color1(color1),
    .color2(color2),
    .grant(grant),
    .cur_r(cur_r),
    .cur_g(cur_g),
    .cur_b(cur_b),
    .settled(settled),
    .rgb_r_pwm(rgb_r_pwm),
    .rgb_g_pwm(rgb_g_pwm),
    .rgb_b_pwm(rgb_b_pwm)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic count_pwm();
    nr = 0;
    ng = 0;
    nb = 0;
    for (int i = 0; i < 256; i++) begin
      cyc(1);
      nr += int'(rgb_r_pwm);
      ng += int'(rgb_g_pwm);
      nb += int'(rgb_b_pwm);
    end
  endtask
  initial begin
    rst = 1'b1;
    req = 3'b000;
    color0 = 24'h0;
    color1 = 24'h0;
    color2 = 24'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", int'(grant), 0);
    check("rst_cur", int'({cur_r, cur_g, cur_b}), 0);
    check("rst_settled", int'(settled), 1);
    check("rst_pwm", int'({rgb_r_pwm, rgb_g_pwm, rgb_b_pwm}), 0);
    rst = 1'b0;
    cyc(50);
    check("idle_grant", int'(grant), 0);
    check("idle_cur", int'({cur_r, cur_g, cur_b}), 0);
    check("idle_settled", int'(settled), 1);
    check("idle_pwm", int'({rgb_r_pwm, rgb_g_pwm, rgb_b_pwm}), 0);
    color2 = 24'h030201;
    req = 3'b100;
    cyc(1);
    check("g2_grant", int'(grant), 3'b100);
    check("g2_cur0", int'({cur_r, cur_g, cur_b}), 0);
    cyc(1);
    check("g2_tick1", int'({cur_r, cur_g, cur_b}), 24'h010101);
    cyc(4);
    check("g2_tick2", int'({cur_r, cur_g, cur_b}), 24'h020201);
    check("g2_unsettled", int'(settled), 0);
    cyc(4);
    check("g2_tick3", int'({cur_r, cur_g, cur_b}), 24'h030201);
    check("g2_settled", int'(settled), 1);
    count_pwm();
    check("g2_duty_r", nr, 3);
    check("g2_duty_g", ng, 2);
    check("g2_duty_b", nb, 1);
    color0 = 24'h000000;
    req = 3'b101;
    cyc(1);
    check("pre_grant", int'(grant), 3'b001);
    cyc(3);
    check("pre_ramp", int'({cur_r, cur_g, cur_b}), 24'h020100);
    cyc(8);
    check("pre_zero", int'({cur_r, cur_g, cur_b}), 0);
    check("pre_settled", int'(settled), 1);
    req = 3'b010;
    cyc(8);
    check("hold0_kept", int'(grant), 3'b001);
    cyc(1);
    check("hold0_pass", int'(grant), 3'b010);
    req = 3'b000;
    cyc(7);
    check("hold1_kept", int'(grant), 3'b010);
    cyc(1);
    check("hold1_idle", int'(grant), 0);
    req = 3'b010;
    cyc(1);
    check("hold2_grant", int'(grant), 3'b010);
    req = 3'b100;
    cyc(6);
    check("hold2_kept", int'(grant), 3'b010);
    cyc(1);
    check("hold2_pass", int'(grant), 3'b100);
    color2 = 24'hFF0000;
    cyc(1100);
    check("full_cur", int'({cur_r, cur_g, cur_b}), 24'hFF0000);
    check("full_settled", int'(settled), 1);
    count_pwm();
    check("full_duty_r", nr, 255);
    check("full_duty_g", ng, 0);
    check("full_nowrap", int'(cur_r), 255);
    #2 rst = 1'b1;
    #1;
    check("async_rst_cur", int'(cur_r), 0);
    check("async_rst_grant", int'(grant), 0);
    rst = 1'b0;
    cyc(1);
    check("rf_grant", int'(grant), 3'b100);
    cyc(19);
    check("rf_cur5", int'(cur_r), 5);
    #2 rst = 1'b1;
    #1;
    check("rf_rst_cur", int'({cur_r, cur_g, cur_b}), 0);
    check("rf_rst_grant", int'(grant), 0);
    check("rf_rst_pwm", int'({rgb_r_pwm, rgb_g_pwm, rgb_b_pwm}), 0);
    check("rf_rst_settled", int'(settled), 1);
    rst = 1'b0;
    cyc(3);
    check("rf_restart0", int'(cur_r), 0);
    cyc(1);
    check("rf_restart1", int'(cur_r), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rgb_led_arbiter.md
Name: rgb_led_arbiter

Overview:
- Shares the single board RGB LED between three status requesters.
- Each requester asserts a request and presents a 24-bit {R,G,B} colour; a fixed-priority arbiter with a minimum-hold timer selects one.
- Displayed channel amounts fade one step per fade tick toward the granted colour. The block generates the three 8-bit PWM waveforms that drive the SB_RGBA_DRV RGB0PWM/RGB1PWM/RGB2PWM pins.
- Sits between status logic (button, activity, error) and the RGB driver primitive.

Parameters:
- PWM_DIV, 99: PWM counter advances once every PWM_DIV+1 clocks.
- FADE_DIV, 19999: fade/hold tick fires once every FADE_DIV+1 clocks.
- MIN_HOLD, 250: fade ticks a grant is kept after its request drops, unless preempted.

Ports:
- CLK_10MHz  in  1  system clock
- RST  in  1  asynchronous active-high reset
- req  in  3  request lines; req[0] highest priority, req[2] lowest
- color0  in  24  requester 0 colour {R[23:16],G[15:8],B[7:0]}
- color1  in  24  requester 1 colour
- color2  in  24  requester 2 colour
- grant  out  3  one-hot current owner; 0 when idle
- cur_r, cur_g, cur_b  out  8 each  currently displayed amounts
- settled  out  1  high when cur equals target on all three channels
- rgb_r_pwm, rgb_g_pwm, rgb_b_pwm  out  1 each  PWM to the RGB driver

Behaviour:
- Interface: one clock, CLK_10MHz. Reset RST is asynchronous and active-high.
- Reset values:
  - All counters 0, state IDLE, grant=0, cur_*=0, pwm outputs 0, hold_cnt=0.
  - settled=1, since target and cur are both 0.
- Prescalers:
  - pwm_div_cnt counts 0..PWM_DIV; pwm_tick is high for the one clock where the count equals PWM_DIV, and the count wraps to 0.
  - fade_tick is generated identically using FADE_DIV.
  - Both prescalers free-run from reset.
- PWM:
  - 8-bit pwm_cnt increments on pwm_tick and wraps 255->0.
  - On pwm_tick, rgb_x_pwm <= (pwm_cnt < cur_x), compared using pre-increment pwm_cnt and current cur_x.
  - cur=0 gives a constantly-low output; cur=255 gives 255/256 duty.
- Target:
  - target = colour of the granted requester, sampled live each clock.
  - In IDLE, target = 0.
- Arbiter FSM (evaluated every clock):
  - IDLE: if req!=0, grant the highest-priority set bit, hold_cnt<=MIN_HOLD, go to ACTIVE. Otherwise stay in IDLE.
  - ACTIVE, preemption: if a strictly higher-priority req bit is set, grant it immediately and reload hold_cnt<=MIN_HOLD. Preemption takes precedence over every other rule.
  - ACTIVE, request still held: hold_cnt reloads to MIN_HOLD every clock.
  - ACTIVE, request dropped: hold_cnt decrements by 1 on each fade_tick, saturating at 0. While hold_cnt>0 the grant is kept and the colour keeps displaying.
  - ACTIVE, hold expired: when the request is dropped and hold_cnt==0, regrant the highest pending lower-priority requester (reloading hold), or go to IDLE with grant=0 if none.
  - MIN_HOLD=0: release happens on the first clock after the request drops.
- Fade:
  - On fade_tick, each cur_x moves by +1 if below target, -1 if above, and is unchanged if equal. No overshoot or wrap.
  - Fade uses the target from the grant registered at the start of the cycle. A grant change in the same cycle affects the next tick.
- settled is combinational: (cur_r,cur_g,cur_b)==target.
- Colour inputs may change while granted; the fade tracks the new value.
- RST mid-fade or mid-hold returns everything to reset values asynchronously. The first ticks after release occur PWM_DIV+1 and FADE_DIV+1 clocks later.

Test Plan:
Benches use PWM_DIV=0, FADE_DIV=3, MIN_HOLD=2.
- Reset then idle 50 clocks -> grant=0, cur_*=0, all pwm low, settled=1.
- req=3'b100, color2=24'h030201 -> grant=3'b100 next clock; cur steps 1 per 4 clocks to (3,2,1), settled=1 after 3 fade ticks; over 256 clocks rgb_r_pwm high exactly 3 cycles, rgb_g_pwm 2, rgb_b_pwm 1.
- With req[2] granted and settled, assert req[0] with color0=24'h000000 -> grant=3'b001 the next clock; cur_* ramps down to 0.
- Grant req[1], drop req[1] -> grant holds through 2 fade ticks, then goes to IDLE; pending req[2] set during the hold -> grant=3'b100 instead of IDLE.
- color=24'hFF0000 settled -> rgb_r_pwm low for exactly 1 of every 256 clocks; cur_r never wraps past 255.
- Assert RST mid-fade (cur_r=5) -> outputs zero immediately, without waiting for a clock edge; after release with req held, the fade restarts from 0.
